// File: rtl/button_conditioner_if.sv
// ----------------------------------------------------------------------------
// button_conditioner_if
//   Bundles the button-side signals of the button conditioner.
//
//   btn_in    : raw, asynchronous, bouncing button pins (active-high)
//   btn_pulse : registered single-cycle press pulses, zero or one-hot
//   btn_level : registered debounced level per button
//
//   master : the pin/board side (drives btn_in, observes the outputs)
//   slave  : the conditioner itself
// ----------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_level;

    modport master (
        output btn_in,
        input  btn_pulse,
        input  btn_level
    );

    modport slave (
        input  btn_in,
        output btn_pulse,
        output btn_level
    );
endinterface

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//   Five-button front end for the digital clock. Synchronises the raw pins,
//   debounces each one, and emits single-cycle, strictly one-hot press pulses.
//   Buttons selected by REPEAT_MASK auto-repeat while held.
//
//   Ports:
//     clk    : 200 Hz scan clock, all state changes on the rising edge
//     rst    : asynchronous active-low reset (0 = reset)
//     btn_if : slave modport carrying btn_in / btn_pulse / btn_level
//
//   Bit order of every vector: {U, D, R, L, C}, bit 4 = U, bit 0 = C.
//   REPEAT_RATE is expected to be no larger than REPEAT_DELAY.
// ----------------------------------------------------------------------------
module button_conditioner #(
    parameter int               N_BTN          = 5,
    parameter int               DEBOUNCE_TICKS = 4,
    parameter int               REPEAT_DELAY   = 100,
    parameter int               REPEAT_RATE    = 20,
    parameter logic [N_BTN-1:0] REPEAT_MASK    = 5'b11000
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  btn_if
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [DW-1:0] D_ONE    = DW'(1);
    localparam logic [RW-1:0] R_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [RW-1:0] R_ONE    = RW'(1);

    logic [N_BTN-1:0] s0_q;
    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] pulse_q;
    logic [N_BTN-1:0] pulse_d;
    logic [DW-1:0]    dcnt_q [N_BTN];
    logic [DW-1:0]    dcnt_d [N_BTN];
    logic [RW-1:0]    rcnt_q [N_BTN];
    logic [RW-1:0]    rcnt_d [N_BTN];
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rep;
    logic [N_BTN-1:0] cand;

    always_comb begin
        level_d = level_q;
        press   = '0;
        rep     = '0;
        for (int i = 0; i < N_BTN; i++) begin
            dcnt_d[i] = dcnt_q[i];
            rcnt_d[i] = '0;

            // Any sample agreeing with the accepted level restarts the count,
            // so only an unbroken run of DEBOUNCE_TICKS mismatches is accepted.
            if (s1_q[i] == level_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == D_LAST) begin
                level_d[i] = s1_q[i];
                dcnt_d[i]  = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + D_ONE;
            end

            press[i] = level_d[i] & ~level_q[i];

            // Counter runs on the pre-edge level; a repeat that would land on
            // the release edge is suppressed so it never follows the release.
            if (REPEAT_MASK[i]) begin
                if (press[i]) begin
                    rcnt_d[i] = '0;
                end else if (level_q[i]) begin
                    if (rcnt_q[i] == R_LAST) begin
                        rcnt_d[i] = R_RELOAD;
                        rep[i]    = level_d[i];
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + R_ONE;
                    end
                end
            end
        end
    end

    // Highest index wins; losers are simply dropped for this cycle.
    always_comb begin
        cand    = press | rep;
        pulse_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (cand[i]) begin
                pulse_d    = '0;
                pulse_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q    <= '0;
            s1_q    <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_q[i] <= '0;
                rcnt_q[i] <= '0;
            end
        end else begin
            s0_q    <= btn_if.btn_in;
            s1_q    <= s0_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    assign btn_if.btn_pulse = pulse_q;
    assign btn_if.btn_level = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with default parameters
//   (DEBOUNCE_TICKS=4, REPEAT_DELAY=100, REPEAT_RATE=20, mask {U,D}).
//   Edge numbering: E1 is the first rising edge that samples a new btn_in.
// ----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N_BTN = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    button_conditioner_if #(.N_BTN(N_BTN)) bif ();

    button_conditioner #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_TICKS (4),
        .REPEAT_DELAY   (100),
        .REPEAT_RATE    (20),
        .REPEAT_MASK    (5'b11000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_if (bif.slave)
    );

    int total  = 0;
    int passed = 0;

    logic [N_BTN-1:0] prev_pulse = '0;

    // Pulse must always be zero or one-hot and never repeat on back-to-back
    // cycles for the same bit.
    always @(posedge clk) begin
        #1;
        total++;
        if (((bif.btn_pulse & (bif.btn_pulse - 5'd1)) != 5'd0) ||
            ((bif.btn_pulse & prev_pulse) != 5'd0))
            $display("FAIL pulse_onehot t=%0t pulse=%b prev=%b required one-hot/zero, no back-to-back",
                     $time, bif.btn_pulse, prev_pulse);
        else
            passed++;
        prev_pulse = bif.btn_pulse;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bif.btn_in = 5'b11111;
        #1 rst = 1'b0;
        #2;
        total++;
        if (bif.btn_pulse !== 5'b0)
            $display("FAIL reset_pulse got %b want %b", bif.btn_pulse, 5'b0);
        else passed++;
        total++;
        if (bif.btn_level !== 5'b0)
            $display("FAIL reset_level got %b want %b", bif.btn_level, 5'b0);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (bif.btn_level !== 5'b0)
                $display("FAIL reset_hold_level got %b want %b", bif.btn_level, 5'b0);
            else passed++;
        end
        bif.btn_in = 5'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (bif.btn_level !== 5'b0 || bif.btn_pulse !== 5'b0)
                $display("FAIL reset_idle got level=%b pulse=%b want 0/0", bif.btn_level, bif.btn_pulse);
            else passed++;
        end
    endtask

    task automatic test_clean_press();
        logic [4:0] exp_p;
        logic [4:0] exp_l;
        bif.btn_in = 5'b00001;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_p = (e == 6) ? 5'b00001 : 5'b0;
            exp_l = (e >= 6) ? 5'b00001 : 5'b0;
            total++;
            if (bif.btn_pulse !== exp_p)
                $display("FAIL press_pulse e=%0d got %b want %b", e, bif.btn_pulse, exp_p);
            else passed++;
            total++;
            if (bif.btn_level !== exp_l)
                $display("FAIL press_level e=%0d got %b want %b", e, bif.btn_level, exp_l);
            else passed++;
        end
        bif.btn_in = 5'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_l = (e >= 6) ? 5'b0 : 5'b00001;
            total++;
            if (bif.btn_pulse !== 5'b0)
                $display("FAIL release_pulse e=%0d got %b want %b", e, bif.btn_pulse, 5'b0);
            else passed++;
            total++;
            if (bif.btn_level !== exp_l)
                $display("FAIL release_level e=%0d got %b want %b", e, bif.btn_level, exp_l);
            else passed++;
        end
    endtask

    task automatic test_bounce();
        logic bseq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0] exp_p;
        logic [4:0] exp_l;
        for (int k = 0; k < 5; k++) begin
            bif.btn_in = {2'b00, bseq[k], 2'b00};
            tick();
            total++;
            if (bif.btn_pulse !== 5'b0 || bif.btn_level !== 5'b0)
                $display("FAIL bounce_quiet k=%0d got pulse=%b level=%b want 0/0",
                         k, bif.btn_pulse, bif.btn_level);
            else passed++;
        end
        bif.btn_in = 5'b00100;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_p = (e == 6) ? 5'b00100 : 5'b0;
            exp_l = (e >= 6) ? 5'b00100 : 5'b0;
            total++;
            if (bif.btn_pulse !== exp_p)
                $display("FAIL bounce_pulse e=%0d got %b want %b", e, bif.btn_pulse, exp_p);
            else passed++;
            total++;
            if (bif.btn_level !== exp_l)
                $display("FAIL bounce_level e=%0d got %b want %b", e, bif.btn_level, exp_l);
            else passed++;
        end
        bif.btn_in = 5'b0;
        for (int e = 1; e <= 8; e++) tick();
        total++;
        if (bif.btn_level !== 5'b0)
            $display("FAIL bounce_release got %b want %b", bif.btn_level, 5'b0);
        else passed++;
    endtask

    task automatic test_hold(input int b, input bit rep_en);
        logic [4:0] one;
        logic [4:0] exp_p;
        logic [4:0] exp_l;
        one = 5'b0;
        one[b] = 1'b1;
        bif.btn_in = one;
        for (int e = 1; e <= 150; e++) begin
            tick();
            exp_p = ((e == 6) || (rep_en && e >= 106 && ((e - 106) % 20) == 0)) ? one : 5'b0;
            exp_l = (e >= 6) ? one : 5'b0;
            total++;
            if (bif.btn_pulse !== exp_p)
                $display("FAIL hold_pulse b=%0d e=%0d got %b want %b", b, e, bif.btn_pulse, exp_p);
            else passed++;
            total++;
            if (bif.btn_level !== exp_l)
                $display("FAIL hold_level b=%0d e=%0d got %b want %b", b, e, bif.btn_level, exp_l);
            else passed++;
        end
        bif.btn_in = 5'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            exp_l = (e >= 6) ? 5'b0 : one;
            total++;
            if (bif.btn_pulse !== 5'b0)
                $display("FAIL hold_release_pulse b=%0d e=%0d got %b want %b", b, e, bif.btn_pulse, 5'b0);
            else passed++;
            total++;
            if (bif.btn_level !== exp_l)
                $display("FAIL hold_release_level b=%0d e=%0d got %b want %b", b, e, bif.btn_level, exp_l);
            else passed++;
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp_p;
        logic [4:0] exp_l;
        bif.btn_in = 5'b10001;
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp_p = (e == 6) ? 5'b10000 : 5'b0;
            exp_l = (e >= 6) ? 5'b10001 : 5'b0;
            total++;
            if (bif.btn_pulse !== exp_p)
                $display("FAIL simul_pulse e=%0d got %b want %b", e, bif.btn_pulse, exp_p);
            else passed++;
            total++;
            if (bif.btn_level !== exp_l)
                $display("FAIL simul_level e=%0d got %b want %b", e, bif.btn_level, exp_l);
            else passed++;
        end
        bif.btn_in = 5'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if (bif.btn_pulse !== 5'b0)
                $display("FAIL simul_release_pulse e=%0d got %b want %b", e, bif.btn_pulse, 5'b0);
            else passed++;
        end
        total++;
        if (bif.btn_level !== 5'b0)
            $display("FAIL simul_release_level got %b want %b", bif.btn_level, 5'b0);
        else passed++;
    endtask

    task automatic test_reset_mid_repeat();
        logic [4:0] exp_p;
        logic [4:0] exp_l;
        bif.btn_in = 5'b10000;
        for (int e = 1; e <= 106; e++) tick();
        total++;
        if (bif.btn_pulse !== 5'b10000)
            $display("FAIL mid_repeat_pre got %b want %b", bif.btn_pulse, 5'b10000);
        else passed++;
        #2 rst = 1'b0;
        #1;
        total++;
        if (bif.btn_pulse !== 5'b0 || bif.btn_level !== 5'b0)
            $display("FAIL mid_repeat_async got pulse=%b level=%b want 0/0", bif.btn_pulse, bif.btn_level);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (bif.btn_pulse !== 5'b0 || bif.btn_level !== 5'b0)
                $display("FAIL mid_repeat_held got pulse=%b level=%b want 0/0", bif.btn_pulse, bif.btn_level);
            else passed++;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 110; e++) begin
            tick();
            exp_p = (e == 6 || e == 106) ? 5'b10000 : 5'b0;
            exp_l = (e >= 6) ? 5'b10000 : 5'b0;
            total++;
            if (bif.btn_pulse !== exp_p)
                $display("FAIL rerelease_pulse e=%0d got %b want %b", e, bif.btn_pulse, exp_p);
            else passed++;
            total++;
            if (bif.btn_level !== exp_l)
                $display("FAIL rerelease_level e=%0d got %b want %b", e, bif.btn_level, exp_l);
            else passed++;
        end
        bif.btn_in = 5'b0;
        for (int e = 1; e <= 10; e++) tick();
    endtask

    task automatic test_reset_mid_debounce();
        logic [4:0] exp_p;
        bif.btn_in = 5'b01000;
        for (int e = 1; e <= 4; e++) tick();
        #2 rst = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_p = (e == 6) ? 5'b01000 : 5'b0;
            total++;
            if (bif.btn_pulse !== exp_p)
                $display("FAIL mid_debounce_pulse e=%0d got %b want %b", e, bif.btn_pulse, exp_p);
            else passed++;
        end
        bif.btn_in = 5'b0;
        for (int e = 1; e <= 10; e++) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 15) == 0)
                bif.btn_in = 5'($urandom);
            tick();
        end
        bif.btn_in = 5'b0;
        for (int e = 1; e <= 12; e++) tick();
        total++;
        if (bif.btn_level !== 5'b0 || bif.btn_pulse !== 5'b0)
            $display("FAIL random_settle got level=%b pulse=%b want 0/0", bif.btn_level, bif.btn_pulse);
        else passed++;
    endtask

    initial begin
        bif.btn_in = 5'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold(4, 1'b1);
        test_hold(1, 1'b0);
        test_simultaneous();
        test_reset_mid_repeat();
        test_reset_mid_debounce();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Five-button front end for the digital clock: synchronises the raw push-button pins, debounces them, and emits single-cycle, strictly one-hot press pulses to the mode/adjust state machine. Buttons in `REPEAT_MASK` (U and D by default) auto-repeat while held so hours and minutes can be scrolled. The block sits between the board pins and the clock FSM, clocked by the 200 Hz scan clock.

## Interface
- `N_BTN`, 5, number of buttons; bit order {U, D, R, L, C}, bit 4 = U, bit 0 = C.
- `DEBOUNCE_TICKS`, 4, consecutive stable samples required to accept a level change (>= 1).
- `REPEAT_DELAY`, 100, cycles from the press pulse to the first auto-repeat pulse (>= 1).
- `REPEAT_RATE`, 20, cycles between subsequent auto-repeat pulses (>= 1).
- `REPEAT_MASK`, 5'b11000, per-button auto-repeat enable.
- `clk` input 1: single clock (200 Hz scan clock); all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `btn_in` input N_BTN: raw, asynchronous, bouncing button pins, active-high.
- `btn_pulse` output N_BTN: registered press pulses, one cycle wide, never more than one bit set.
- `btn_level` output N_BTN: registered debounced level per button.

## Operation
- Synchroniser: per bit, two flops `s0 <= btn_in`, `s1 <= s0`. Only `s1` is used downstream.
- Debouncer per bit: counter `dcnt` of width clog2(DEBOUNCE_TICKS+1).
  - If `s1 == btn_level`, `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_TICKS-1`, `btn_level <= s1` and `dcnt <= 0`.
  - Else `dcnt <= dcnt+1`.
  - Any single matching sample restarts the count. Bounces shorter than DEBOUNCE_TICKS samples are filtered out.
- Press candidate: asserted on the edge where `btn_level` goes 0->1. Release generates nothing.
- Auto-repeat per bit, only where `REPEAT_MASK` = 1: counter `rcnt` of width clog2(REPEAT_DELAY+1).
  - On the press edge, `rcnt <= 0`.
  - While `btn_level` = 1, `rcnt` increments.
  - When `rcnt` reaches REPEAT_DELAY-1, raise a repeat candidate and load `rcnt <= REPEAT_DELAY-REPEAT_RATE`. Candidates then recur every REPEAT_RATE cycles.
  - While `btn_level` = 0, `rcnt` is held at 0.
  - For bits with mask = 0, `rcnt` stays at 0 and never produces a candidate.
- Arbitration: in each cycle the candidates (press OR repeat) are priority-encoded, highest index wins. `btn_pulse` is registered to exactly the winning bit. Losing candidates are discarded, not queued.
- Arbitration does not affect `btn_level`.

## Timing
- Reset (`rst` = 0, asynchronous): `s0`, `s1`, `btn_level`, `btn_pulse`, `dcnt`, `rcnt` all cleared to 0 immediately, regardless of `clk`.
- Press latency: edge E1 is the first edge that samples `btn_in` = 1 into `s0`. `s1` = 1 after E2; mismatches are counted on E3..E(2+DEBOUNCE_TICKS). `btn_level` and `btn_pulse` rise together after edge E(DEBOUNCE_TICKS+2), i.e. E6 for the default.
- `btn_pulse` lasts exactly 1 cycle per event.
- Release latency: `btn_level` falls DEBOUNCE_TICKS+2 edges after the first low sample. No pulse is produced on release.
- First repeat: REPEAT_DELAY cycles after the press pulse. Later repeats: every REPEAT_RATE cycles.
- Repeats stop on the edge `btn_level` falls. A repeat cannot coincide with that edge: the counter is gated by the pre-edge level.
- Button held while `rst` deasserts: the button is treated as a fresh press and yields a pulse DEBOUNCE_TICKS+2 edges after release of reset.
- Reset asserted mid-debounce or mid-repeat: all progress is lost and no pulse is emitted.
- Simultaneous press qualification on several buttons: only the highest index pulses. The others keep `btn_level` = 1 but never emit their press pulse.
- A repeat collision is dropped for that slot only; the next repeat still comes REPEAT_RATE cycles later.

## Test plan
- Clean press of C (`btn_in` = 5'b00001) held 10 cycles from reset -> `btn_pulse` = 5'b00001 for one cycle after edge 6; `btn_level[0]` = 1 from edge 6; no further pulses; `btn_level[0]` falls 6 edges after release.
- Bounce: R toggles 1,0,1,1,0,1 (runs < 4 samples), then stable 1 -> exactly one `btn_pulse` = 5'b00100, 6 edges after the start of the stable run; no pulse during the bounce.
- U held 150 cycles -> press pulse at edge 6, repeats at edges 106 and 126 and every 20 cycles after; repeats stop after release. L held 150 cycles (mask 0) -> single pulse only.
- U and C rising on the same cycle -> only `btn_pulse` = 5'b10000 is emitted; `btn_level` = 5'b10001; C never pulses while held.
- `rst` driven 0 mid-repeat, asynchronously between clock edges -> all outputs 0 immediately. Button still held at `rst` = 1 -> new press pulse 6 edges later, first repeat 100 cycles after that.
- Random presses on all 5 pins for 10k cycles -> assertion holds that `btn_pulse` is always zero or one-hot and never high on two consecutive cycles for the same bit.
